// File: rtl/phase_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// phase_sweep_ctrl
//
// Receive-phase acquisition controller for the QPSK link. Steps the rx
// sampling phase through all UPSAMPLE candidates. For each candidate it
// first lets the receive pipeline settle for SETTLE_SYMS symbols. It then
// counts reference/received bit disagreements over a window of
// 2^WINDOW_LOG2 symbols. At the end of the sweep it parks on the phase
// with the fewest errors.
//
// Optional feature macro: PHASE_TRACK_EN
//   defined   - while locked, keep measuring back-to-back windows on the
//               held phase; a window with more than THRESH errors drops
//               lock and relaunches the full sweep on its own.
//   undefined - the locked state is static until start or rst.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enable     in   symbol strobe, one cycle per symbol
//   start      in   sweep request (level, sampled every cycle)
//   sx         in   reference PRBS bit, delay-matched to dx
//   dx         in   demodulated bit
//   phase      out  sampling phase to the receiver
//   ber_rst    out  one-cycle clear pulse for the downstream BER monitor
//   busy       out  sweep in progress
//   done       out  one-cycle pulse when a sweep completes
//   locked     out  best window error count <= THRESH
//   best_errs  out  error count of the selected phase
// ---------------------------------------------------------------------------
module phase_sweep_ctrl #(
   parameter int UPSAMPLE    = 4,
   parameter int PH_W        = 2,
   parameter int WINDOW_LOG2 = 10,
   parameter int SETTLE_SYMS = 8,
   parameter int THRESH      = 0,
   parameter int CNT_W       = WINDOW_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             sx,
   input  logic             dx,
   output logic [PH_W-1:0]  phase,
   output logic             ber_rst,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic [CNT_W-1:0] best_errs
);

   typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, LOCK} state_t;

   localparam logic [PH_W-1:0]  LAST_PHASE  = PH_W'(UPSAMPLE - 1);
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_SYMS - 1);
   localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] ERR_MAX     = '1;

   state_t                 state, state_nx;
   logic [PH_W-1:0]        phase_nx, best_phase, best_phase_nx, cand_phase;
   logic [CNT_W-1:0]       best_errs_nx, err_cnt, err_cnt_nx, err_inc, cand_errs;
   logic [WINDOW_LOG2-1:0] sym_cnt, sym_cnt_nx;
   logic [7:0]             settle_cnt, settle_cnt_nx;
   logic                   ber_rst_nx, busy_nx, done_nx, locked_nx;
   logic                   window_end, restart;

   // The error counter saturates instead of wrapping, so a pathological
   // window can never look better than it really was.
   assign err_inc    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + CNT_W'(sx ^ dx);
   // The strobe that fills the last slot of a window is still counted.
   assign window_end = enable && (&sym_cnt);

   // Candidate for the best-so-far after the window just finished. The
   // comparison is strict, so on a tie the earlier (lower) phase stays.
   always_comb begin
      cand_errs  = best_errs;
      cand_phase = best_phase;
      if (err_cnt < best_errs) begin
         cand_errs  = err_cnt;
         cand_phase = phase;
      end
   end

   // Next-state and next-output logic. Every output is computed here as a
   // next value and then registered. A restart request from IDLE or LOCK is
   // collected in 'restart' and applied after the case statement, so the
   // sweep launch looks the same wherever it comes from.
   always_comb begin
      state_nx      = state;
      phase_nx      = phase;
      best_phase_nx = best_phase;
      best_errs_nx  = best_errs;
      err_cnt_nx    = err_cnt;
      sym_cnt_nx    = sym_cnt;
      settle_cnt_nx = settle_cnt;
      locked_nx     = locked;
      ber_rst_nx    = 1'b0;
      done_nx       = 1'b0;
      restart       = 1'b0;

      case (state)
         IDLE: begin
            restart = start;
         end

         SETTLE: begin
            if (enable) begin
               if (settle_cnt == SETTLE_LAST) begin
                  state_nx   = MEASURE;
                  err_cnt_nx = '0;
                  sym_cnt_nx = '0;
               end else begin
                  settle_cnt_nx = settle_cnt + 8'd1;
               end
            end
         end

         MEASURE: begin
            if (enable) begin
               err_cnt_nx = err_inc;
               sym_cnt_nx = sym_cnt + WINDOW_LOG2'(1);
               if (window_end) begin
                  state_nx = EVAL;
               end
            end
         end

         EVAL: begin
            best_errs_nx  = cand_errs;
            best_phase_nx = cand_phase;
            ber_rst_nx    = 1'b1;
            if (phase == LAST_PHASE) begin
               state_nx   = LOCK;
               phase_nx   = cand_phase;
               locked_nx  = (cand_errs <= THRESH_C);
               done_nx    = 1'b1;
               err_cnt_nx = '0;
               sym_cnt_nx = '0;
            end else begin
               state_nx      = SETTLE;
               phase_nx      = phase + PH_W'(1);
               settle_cnt_nx = '0;
            end
         end

         LOCK: begin
            restart = start;
`ifdef PHASE_TRACK_EN
            if (enable) begin
               err_cnt_nx = err_inc;
               sym_cnt_nx = sym_cnt + WINDOW_LOG2'(1);
               if (window_end) begin
                  err_cnt_nx = '0;
                  if (err_inc > THRESH_C) begin
                     restart = 1'b1;
                  end
               end
            end
`endif
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      if (restart) begin
         state_nx      = SETTLE;
         phase_nx      = '0;
         best_errs_nx  = '1;
         best_phase_nx = '0;
         settle_cnt_nx = '0;
         locked_nx     = 1'b0;
         ber_rst_nx    = 1'b1;
      end

      busy_nx = (state_nx == SETTLE) || (state_nx == MEASURE) || (state_nx == EVAL);
   end

   // State and output registers. Reset wins over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         best_phase <= '0;
         best_errs  <= '0;
         err_cnt    <= '0;
         sym_cnt    <= '0;
         settle_cnt <= '0;
         ber_rst    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_nx;
         phase      <= phase_nx;
         best_phase <= best_phase_nx;
         best_errs  <= best_errs_nx;
         err_cnt    <= err_cnt_nx;
         sym_cnt    <= sym_cnt_nx;
         settle_cnt <= settle_cnt_nx;
         ber_rst    <= ber_rst_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         locked     <= locked_nx;
      end
   end

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phase_sweep_ctrl
//
// Drives two phase_sweep_ctrl instances (THRESH=0 and THRESH=3) with the
// same inputs. The bench plans a number of bit errors per phase and keeps
// its own count of counted symbol strobes. From that count it works out
// which phase is active and which window slot the next strobe fills.
// Expected results come from the plan: the minimum error count, with the
// lowest phase winning a tie.
// ---------------------------------------------------------------------------
module tb_phase_sweep_ctrl;

   localparam int UPS   = 4;
   localparam int PHW   = 2;
   localparam int WL    = 4;
   localparam int SS    = 2;
   localparam int CW    = WL + 1;
   localparam int WIN   = 1 << WL;
   localparam int PER   = SS + WIN;
   localparam int TOTAL = UPS * PER;

   logic           clk = 1'b0;
   logic           rst, enable, start, sx, dx;
   logic [PHW-1:0] phase, phase3;
   logic           ber_rst, busy, done, locked;
   logic           ber_rst3, busy3, done3, locked3;
   logic [CW-1:0]  best_errs, best_errs3;

   int tests    = 0;
   int failures = 0;
   int cyc      = 0;
   int mode     = 0;
   int k        = 0;
   int lk       = 0;
   int ber_cnt  = 0;
   int done_cnt = 0;
   int plan [UPS];
   logic [WIN-1:0] mask [UPS];
   logic [WIN-1:0] lock_mask = '0;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   phase_sweep_ctrl #(.UPSAMPLE(UPS), .PH_W(PHW), .WINDOW_LOG2(WL),
                      .SETTLE_SYMS(SS), .THRESH(0), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .sx(sx), .dx(dx),
      .phase(phase), .ber_rst(ber_rst), .busy(busy), .done(done),
      .locked(locked), .best_errs(best_errs));

   phase_sweep_ctrl #(.UPSAMPLE(UPS), .PH_W(PHW), .WINDOW_LOG2(WL),
                      .SETTLE_SYMS(SS), .THRESH(3), .CNT_W(CW)) dut_t3 (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .sx(sx), .dx(dx),
      .phase(phase3), .ber_rst(ber_rst3), .busy(busy3), .done(done3),
      .locked(locked3), .best_errs(best_errs3));

   // Hard stop in case the stimulus ever runs away
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [WIN-1:0] randMask(input int e);
      logic [WIN-1:0] m;
      int n, b;
      m = '0;
      n = 0;
      while (n < e) begin
         b = $urandom_range(0, WIN - 1);
         if (!m[b]) begin
            m[b] = 1'b1;
            n++;
         end
      end
      return m;
   endfunction

   // One clock cycle. Inputs are driven at the falling edge, the DUT
   // samples them at the rising edge, and outputs are observed at the next
   // falling edge. A strobe arrives every 4th cycle. Mode 1 is a sweep in
   // progress (k counts strobes), mode 2 is locked (lk counts strobes).
   task automatic applyStimulus(input logic st);
      int ph, slot;
      enable = (cyc % 4 == 0);
      start  = st;
      sx     = 1'($urandom);
      dx     = 1'($urandom);
      if (enable && mode == 1) begin
         ph   = k / PER;
         slot = k % PER - SS;
         checkOutput("phase_seq", int'(phase), ph);
         checkOutput("busy_sweep", int'(busy), 1);
         if (slot >= 0) dx = sx ^ mask[ph][slot];
      end else if (enable && mode == 2) begin
         dx = sx ^ lock_mask[lk % WIN];
      end
      @(posedge clk);
      if (enable) begin
         if (mode == 1) k++;
         else if (mode == 2) lk++;
      end
      cyc++;
      @(negedge clk);
      if (ber_rst) ber_cnt++;
      if (done) done_cnt++;
   endtask

   // Full sweep against the current plan, with optional start and optional
   // start noise partway through phase 1.
   task automatic runSweep(input bit do_start, input bit on_strobe, input bit noise);
      int best_p, best_e, nl;
      best_p = 0;
      best_e = plan[0];
      for (int p = 1; p < UPS; p++) begin
         if (plan[p] < best_e) begin
            best_e = plan[p];
            best_p = p;
         end
      end
      for (int p = 0; p < UPS; p++) mask[p] = randMask(plan[p]);
      if (do_start) begin
         for (int g = 0; g < 8 && ((cyc % 4 == 0) != on_strobe); g++) applyStimulus(1'b0);
         ber_cnt  = 0;
         done_cnt = 0;
         applyStimulus(1'b1);
         checkOutput("start_busy", int'(busy), 1);
         checkOutput("start_ber_rst", int'(ber_rst), 1);
         checkOutput("start_phase", int'(phase), 0);
         checkOutput("start_best_errs", int'(best_errs), (1 << CW) - 1);
         checkOutput("start_locked", int'(locked), 0);
         mode = 1;
         k    = 0;
      end
      nl = noise ? 10 : 0;
      for (int g = 0; g < 8 * TOTAL && k < TOTAL; g++) begin
         if (noise && k >= PER + 5 && nl > 0) begin
            applyStimulus(1'b1);
            nl--;
         end else begin
            applyStimulus(1'b0);
         end
      end
      mode = 2;
      lk   = 0;
      checkOutput("ber_rst_before_done", ber_cnt, UPS);
      checkOutput("no_early_done", done_cnt, 0);
      applyStimulus(1'b0);
      checkOutput("done_pulse", int'(done), 1);
      checkOutput("final_phase", int'(phase), best_p);
      checkOutput("final_best_errs", int'(best_errs), best_e);
      checkOutput("final_locked", int'(locked), (best_e <= 0) ? 1 : 0);
      checkOutput("final_phase_t3", int'(phase3), best_p);
      checkOutput("final_best_errs_t3", int'(best_errs3), best_e);
      checkOutput("final_locked_t3", int'(locked3), (best_e <= 3) ? 1 : 0);
      checkOutput("final_busy", int'(busy), 0);
      checkOutput("ber_rst_with_done", ber_cnt, UPS + 1);
      repeat (6) applyStimulus(1'b0);
      checkOutput("single_done", done_cnt, 1);
      checkOutput("phase_held", int'(phase), best_p);
      checkOutput("idle_busy", int'(busy), 0);
   endtask

   // While locked, put 5 errors into one whole tracking window.
   task automatic trackTest();
      int lk0;
      for (int g = 0; g < 128 && !(lk % WIN == 0 && cyc % 4 == 0); g++) applyStimulus(1'b0);
      lk0       = lk;
      lock_mask = randMask(5);
      ber_cnt   = 0;
      done_cnt  = 0;
      for (int g = 0; g < 8 * WIN && lk < lk0 + WIN; g++) applyStimulus(1'b0);
      lock_mask = '0;
`ifdef PHASE_TRACK_EN
      checkOutput("track_unlock", int'(locked), 0);
      checkOutput("track_busy", int'(busy), 1);
      checkOutput("track_ber_rst", int'(ber_rst), 1);
      checkOutput("track_unlock_t3", int'(locked3), 0);
      mode = 1;
      k    = 0;
      runSweep(1'b0, 1'b0, 1'b0);
`else
      checkOutput("static_locked", int'(locked), 1);
      checkOutput("static_busy", int'(busy), 0);
      checkOutput("static_phase", int'(phase), 2);
      checkOutput("static_ber_rst", ber_cnt, 0);
`endif
   endtask

   // Reset during the phase-1 measurement window.
   task automatic abortTest();
      for (int p = 0; p < UPS; p++) mask[p] = randMask($urandom_range(0, WIN));
      applyStimulus(1'b1);
      mode = 1;
      k    = 0;
      for (int g = 0; g < 8 * TOTAL && k < PER + SS + 5; g++) applyStimulus(1'b0);
      rst = 1'b1;
      applyStimulus(1'b1);
      rst  = 1'b0;
      mode = 0;
      checkOutput("abort_phase", int'(phase), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_locked", int'(locked), 0);
      checkOutput("abort_best_errs", int'(best_errs), 0);
      checkOutput("abort_done", int'(done), 0);
      repeat (3) applyStimulus(1'b0);
      checkOutput("abort_stays_idle", int'(busy), 0);
   endtask

   // Main sequence
   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      enable = 1'b0;
      sx     = 1'b0;
      dx     = 1'b0;
      repeat (3) applyStimulus(1'b1);
      checkOutput("rst_phase", int'(phase), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_locked", int'(locked), 0);
      checkOutput("rst_best_errs", int'(best_errs), 0);
      checkOutput("rst_ber_rst", int'(ber_rst), 0);
      rst = 1'b0;
      repeat (2) applyStimulus(1'b0);
      checkOutput("rst_start_ignored", int'(busy), 0);

      $display("[TB] sweep: only phase 2 clean");
      plan = '{WIN, WIN, 0, WIN};
      runSweep(1'b1, 1'b1, 1'b0);
      trackTest();

      $display("[TB] sweep: equal errors at every phase");
      plan = '{3, 3, 3, 3};
      runSweep(1'b1, 1'b0, 1'b0);

      $display("[TB] sweep: all phases bad, start noise mid-sweep");
      plan = '{WIN, WIN, WIN, WIN};
      runSweep(1'b1, 1'b0, 1'b1);

      $display("[TB] reset during measurement");
      abortTest();
      plan = '{9, 5, 12, 5};
      runSweep(1'b1, 1'b0, 1'b0);

      $display("[TB] random plans");
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < UPS; p++) plan[p] = $urandom_range(0, WIN);
         runSweep(1'b1, r[0], 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
